// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if: instruction, register-bank, ALUX and result signals of the issue sequencer.
interface alu_issue_seq_if #(
   parameter int DATA_W = 64,
   parameter int SEL_W  = 4,
   parameter int OPR_W  = 4,
   parameter int TMO_W  = 6
);
   logic              ins_valid;
   logic              ins_ready;
   logic [OPR_W-1:0]  ins_opr;
   logic [SEL_W-1:0]  ins_srca;
   logic [SEL_W-1:0]  ins_srcb;
   logic [SEL_W-1:0]  ins_dst;
   logic [1:0]        ins_wmode;
   logic              ins_wb;
   logic [TMO_W-1:0]  maxclock;
   logic [SEL_W-1:0]  seloutA;
   logic [SEL_W-1:0]  seloutB;
   logic [DATA_W-1:0] rf_outA;
   logic [DATA_W-1:0] rf_outB;
   logic [DATA_W-1:0] alu_inA;
   logic [DATA_W-1:0] alu_inB;
   logic [OPR_W-1:0]  alu_opr;
   logic              alu_start;
   logic [DATA_W-1:0] alu_result;
   logic              alu_done;
   logic              regwen;
   logic [SEL_W-1:0]  selwreg;
   logic [1:0]        endwreg;
   logic [DATA_W-1:0] wdata;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_timeout;
   logic              busy;
   modport slave (
      input  ins_valid, ins_opr, ins_srca, ins_srcb, ins_dst, ins_wmode, ins_wb, maxclock,
             rf_outA, rf_outB, alu_result, alu_done,
      output ins_ready, seloutA, seloutB, alu_inA, alu_inB, alu_opr, alu_start,
             regwen, selwreg, endwreg, wdata, res_valid, res_data, res_timeout, busy
   );
   modport master (
      output ins_valid, ins_opr, ins_srca, ins_srcb, ins_dst, ins_wmode, ins_wb, maxclock,
             rf_outA, rf_outB, alu_result, alu_done,
      input  ins_ready, seloutA, seloutB, alu_inA, alu_inB, alu_opr, alu_start,
             regwen, selwreg, endwreg, wdata, res_valid, res_data, res_timeout, busy
   );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issues one instruction at a time from reg_bank to ALUX and writes the result back.
module alu_issue_seq #(
   parameter int DATA_W = 64,
   parameter int SEL_W  = 4,
   parameter int OPR_W  = 4,
   parameter int TMO_W  = 6
) (
   input logic           clock,
   input logic           reset,
   alu_issue_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, READ, LATCH, START, WAIT, WB, DONE} state_t;
   state_t            state, state_nx;
   logic [OPR_W-1:0]  opr;
   logic [SEL_W-1:0]  dst;
   logic [1:0]        wmode;
   logic              wb;
   logic [TMO_W-1:0]  tmo;
   logic [DATA_W-1:0] res_q;
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.ins_valid ? READ : IDLE;
         READ:    state_nx = LATCH;
         LATCH:   state_nx = START;
         START:   state_nx = WAIT;
         WAIT:    state_nx = bus.alu_done ? (wb ? WB : DONE) : (tmo == TMO_W'(1) ? DONE : WAIT);
         WB:      state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   assign bus.ins_ready = state == IDLE;
   assign bus.busy      = state != IDLE;
   assign bus.alu_start = state == START;
   assign bus.regwen    = state == WB;
   assign bus.res_valid = state == DONE;
   assign bus.res_data  = res_q;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         opr             <= '0;
         dst             <= '0;
         wmode           <= '0;
         wb              <= 1'b0;
         tmo             <= '0;
         res_q           <= '0;
         bus.seloutA     <= '0;
         bus.seloutB     <= '0;
         bus.alu_inA     <= '0;
         bus.alu_inB     <= '0;
         bus.alu_opr     <= '0;
         bus.selwreg     <= '0;
         bus.endwreg     <= '0;
         bus.wdata       <= '0;
         bus.res_timeout <= 1'b0;
      end else begin
         if (state == IDLE && bus.ins_valid) begin
            opr         <= bus.ins_opr;
            dst         <= bus.ins_dst;
            wmode       <= bus.ins_wmode;
            wb          <= bus.ins_wb;
            bus.seloutA <= bus.ins_srca;
            bus.seloutB <= bus.ins_srcb;
         end
         if (state == LATCH) begin
            bus.alu_inA <= bus.rf_outA;
            bus.alu_inB <= bus.rf_outB;
            bus.alu_opr <= opr;
         end
         if (state == START) tmo <= bus.maxclock;
         // done beats the final timeout cycle; tmo==0 never expires
         if (state == WAIT) begin
            if (bus.alu_done) begin
               res_q           <= bus.alu_result;
               bus.res_timeout <= 1'b0;
               if (wb) begin
                  bus.selwreg <= dst;
                  bus.endwreg <= wmode;
                  bus.wdata   <= bus.alu_result;
               end
            end else if (tmo == TMO_W'(1)) bus.res_timeout <= 1'b1;
            else if (tmo != '0) tmo <= tmo - TMO_W'(1);
         end
      end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed and random instructions against a register-bank/ALU environment
// and an instruction-level reference model of outcome, timing and register contents.
module tb_alu_issue_seq;
   logic clock = 1'b0;
   logic reset = 1'b0;
   alu_issue_seq_if bus ();
   alu_issue_seq dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] bank [16];
   logic [63:0] mdl  [16];
   logic [63:0] last_res = '0;
   int          dly = 0;
   int          wc = 0;
   logic        armed = 1'b0;

   function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return a - b;
         default: return a ^ b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // register bank and ALU stub react at the falling edge to the current DUT outputs
   task automatic env();
      if (bus.regwen) bank[bus.selwreg] = bus.wdata;
      bus.rf_outA = bank[bus.seloutA];
      bus.rf_outB = bank[bus.seloutB];
      if (bus.res_valid) armed = 1'b0;
      bus.alu_done   = 1'b0;
      bus.alu_result = {$urandom, $urandom};
      if (bus.alu_start) begin
         armed = 1'b1;
         wc = 0;
      end else if (armed) begin
         wc++;
         if (wc == dly) begin
            bus.alu_done   = 1'b1;
            bus.alu_result = alu_f(bus.alu_opr, bus.alu_inA, bus.alu_inB);
            armed = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      env();
   endtask

   task automatic run(input logic [3:0] op, input int sa, input int sb, input int d, input logic [1:0] wm,
                      input logic w, input int mc, input int dl, input logic hold);
      logic [63:0] a, b, r;
      logic        ok, wen_exp, got;
      int          wt, idx, starts, st_idx, wens, wen_idx, rv_idx;
      logic [3:0]  sel_o;
      logic [1:0]  end_o;
      logic [63:0] wd_o, rd_o;
      logic        to_o;
      a = mdl[sa];
      b = mdl[sb];
      r = alu_f(op, a, b);
      ok = dl != 0 && (mc == 0 || dl <= mc);
      wt = ok ? dl : mc;
      wen_exp = ok && w;
      dly = dl;
      bus.ins_valid = 1'b1;
      bus.ins_opr   = op;
      bus.ins_srca  = 4'(sa);
      bus.ins_srcb  = 4'(sb);
      bus.ins_dst   = 4'(d);
      bus.ins_wmode = wm;
      bus.ins_wb    = w;
      bus.maxclock  = 6'(mc);
      idx = 0; starts = 0; st_idx = -1; wens = 0; wen_idx = -1; rv_idx = -1; got = 1'b0;
      sel_o = '0; end_o = '0; wd_o = '0; rd_o = '0; to_o = 1'b0;
      while (!got && idx < 300) begin
         tick();
         if (idx == 0) begin
            chk("ready_low_busy", bus.ins_ready, 1'b0);
            bus.ins_valid = hold;
            bus.ins_opr   = 4'($urandom);
            bus.ins_srca  = 4'($urandom);
            bus.ins_srcb  = 4'($urandom);
            bus.ins_dst   = 4'($urandom);
            bus.ins_wmode = 2'($urandom);
            bus.ins_wb    = 1'($urandom);
         end
         if (idx == 3) bus.maxclock = 6'($urandom);
         if (bus.alu_start) begin
            starts++;
            st_idx = idx;
            chk("alu_inA", bus.alu_inA, a);
            chk("alu_inB", bus.alu_inB, b);
            chk("alu_opr", bus.alu_opr, op);
         end
         if (bus.regwen) begin
            wens++;
            wen_idx = idx;
            sel_o = bus.selwreg;
            end_o = bus.endwreg;
            wd_o  = bus.wdata;
         end
         if (bus.res_valid) begin
            got = 1'b1;
            rv_idx = idx;
            rd_o = bus.res_data;
            to_o = bus.res_timeout;
            bus.ins_valid = 1'b0;
         end
         idx++;
      end
      if (ok) last_res = r;
      if (wen_exp) mdl[d] = r;
      chk("res_valid_seen", got, 1'b1);
      chk("start_count", starts, 1);
      chk("start_cycle", st_idx, 2);
      chk("regwen_count", wens, wen_exp);
      if (wen_exp) begin
         chk("regwen_cycle", wen_idx, 3 + wt);
         chk("selwreg", sel_o, d);
         chk("endwreg", end_o, wm);
         chk("wdata", wd_o, r);
      end
      chk("res_valid_cycle", rv_idx, 3 + wt + int'(wen_exp));
      chk("res_data", rd_o, last_res);
      chk("res_timeout", to_o, !ok);
      tick();
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_ready", bus.ins_ready, 1'b1);
      chk("bank_readback", bank[d], mdl[d]);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, bus.ins_ready, 1'b1);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_seloutA"}, bus.seloutA, 0);
      chk({tag, "_seloutB"}, bus.seloutB, 0);
      chk({tag, "_alu_inA"}, bus.alu_inA, 0);
      chk({tag, "_alu_inB"}, bus.alu_inB, 0);
      chk({tag, "_alu_opr"}, bus.alu_opr, 0);
      chk({tag, "_alu_start"}, bus.alu_start, 0);
      chk({tag, "_regwen"}, bus.regwen, 0);
      chk({tag, "_selwreg"}, bus.selwreg, 0);
      chk({tag, "_endwreg"}, bus.endwreg, 0);
      chk({tag, "_wdata"}, bus.wdata, 0);
      chk({tag, "_res_valid"}, bus.res_valid, 0);
      chk({tag, "_res_data"}, bus.res_data, 0);
      chk({tag, "_res_timeout"}, bus.res_timeout, 0);
   endtask

   initial begin
      int mc, dl;
      bus.ins_valid = 1'b0; bus.ins_opr = '0; bus.ins_srca = '0; bus.ins_srcb = '0;
      bus.ins_dst = '0; bus.ins_wmode = '0; bus.ins_wb = 1'b0; bus.maxclock = '0;
      bus.rf_outA = '0; bus.rf_outB = '0; bus.alu_result = '0; bus.alu_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bank[i] = {$urandom, $urandom};
         mdl[i] = bank[i];
      end
      bank[3] = 64'd5; mdl[3] = 64'd5;
      bank[4] = 64'd7; mdl[4] = 64'd7;
      repeat (2) @(negedge clock);
      chk_reset_outputs("rst");
      reset = 1'b1;
      repeat (3) tick();
      chk("post_rst_busy", bus.busy, 1'b0);
      chk("post_rst_ready", bus.ins_ready, 1'b1);
      run(4'd2, 3, 4, 5, 2'd1, 1'b1, 38, 3, 1'b0);
      chk("r5_is_12", bank[5], 64'd12);
      run(4'd2, 1, 2, 9, 2'd2, 1'b1, 4, 0, 1'b0);
      run(4'd3, 3, 4, 7, 2'd3, 1'b1, 4, 4, 1'b0);
      run(4'd2, 3, 4, 8, 2'd0, 1'b1, 0, 50, 1'b0);
      run(4'd2, 3, 4, 5, 2'd1, 1'b1, 10, 1, 1'b1);
      run(4'd2, 5, 5, 6, 2'd1, 1'b1, 10, 2, 1'b1);
      chk("r6_is_24", bank[6], 64'd24);
      run(4'd1, 6, 3, 2, 2'd0, 1'b0, 3, 2, 1'b0);
      bus.ins_valid = 1'b1; bus.ins_opr = 4'd2; bus.ins_srca = 4'd3; bus.ins_srcb = 4'd4;
      bus.ins_dst = 4'd10; bus.ins_wb = 1'b1; bus.maxclock = '0; dly = 0;
      tick();
      bus.ins_valid = 1'b0;
      repeat (6) tick();
      chk("wait_busy", bus.busy, 1'b1);
      reset = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clock);
      reset = 1'b1;
      armed = 1'b0;
      bus.alu_done = 1'b0;
      last_res = '0;
      tick();
      chk("r10_untouched", bank[10], mdl[10]);
      run(4'd2, 3, 4, 10, 2'd2, 1'b1, 5, 2, 1'b0);
      for (int k = 0; k < 20; k++) begin
         mc = $urandom_range(0, 10);
         dl = (mc == 0) ? $urandom_range(1, 12) : $urandom_range(0, 12);
         run(4'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             2'($urandom), 1'($urandom), mc, dl, 1'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
